// File: rtl/ascii_decimal_parser.sv
`default_nettype none
// ============================================================================
// Module   : ascii_decimal_parser
// Brief    : Byte-serial ASCII decimal to binary converter with optional sign,
//            overflow, bad-character and empty-number detection.
// Revision : 1.0
// ============================================================================
module ascii_decimal_parser #(
    parameter int MAX_DIGITS = 3,
    parameter int OUT_W      = 10,
    parameter int ALLOW_SIGN = 0,
    parameter int FIXED_LEN  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in,
    input  logic             w_RX_dv,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int ACC_W = OUT_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [ACC_W-1:0] c_one     = ACC_W'(1);
    localparam logic [ACC_W-1:0] c_ten     = ACC_W'(10);
    localparam logic [ACC_W-1:0] c_lim_neg = c_one << (OUT_W - 1);
    localparam logic [ACC_W-1:0] c_lim_pos = c_lim_neg - c_one;
    localparam logic [ACC_W-1:0] c_lim_uns = (c_one << OUT_W) - c_one;
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DIGITS);

    localparam logic [1:0] c_code_char  = 2'd1;
    localparam logic [1:0] c_code_ovf   = 2'd2;
    localparam logic [1:0] c_code_empty = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_neg, w_neg_nxt;
    logic [OUT_W-1:0]   r_out, w_out_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_err, w_err_nxt;
    logic [1:0]         r_err_code, w_err_code_nxt;

    logic               w_is_digit, w_is_term, w_is_minus;
    logic [ACC_W-1:0]   w_base, w_sum, w_limit, w_commit_src;
    logic               w_over;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_commit, w_fail;
    logic [1:0]         w_fail_code;

    assign w_is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign w_is_term  = (in == 8'h0A) || (in == 8'h0D) || (in == 8'h20) || (in == 8'h2C);
    assign w_is_minus = (ALLOW_SIGN != 0) && (in == 8'h2D);

    // In IDLE the new digit starts a fresh number, so the running value is zero.
    assign w_base    = (r_state == S_ACCUM) ? r_acc : '0;
    assign w_sum     = (w_base * c_ten) + ACC_W'(in[3:0]);
    assign w_limit   = (ALLOW_SIGN == 0) ? c_lim_uns : (r_neg ? c_lim_neg : c_lim_pos);
    assign w_over    = (w_sum > w_limit);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_neg_nxt       = r_neg;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_err_code_nxt  = r_err_code;
        w_commit        = 1'b0;
        w_fail          = 1'b0;
        w_fail_code     = 2'd0;
        w_commit_src    = w_sum;

        if (w_RX_dv) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_term) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_is_digit) begin
                        if (w_over) begin
                            w_fail      = 1'b1;
                            w_fail_code = c_code_ovf;
                        end else if ((FIXED_LEN != 0) && (MAX_DIGITS == 1)) begin
                            w_commit = 1'b1;
                        end else begin
                            w_acc_nxt   = w_sum;
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = S_ACCUM;
                        end
                    end else if (w_is_minus) begin
                        w_neg_nxt   = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = c_code_char;
                    end
                end
                S_ACCUM: begin
                    if (w_is_digit) begin
                        if ((r_cnt == c_max_cnt) || w_over) begin
                            w_fail      = 1'b1;
                            w_fail_code = c_code_ovf;
                        end else if ((FIXED_LEN != 0) && (w_cnt_inc == c_max_cnt)) begin
                            w_commit = 1'b1;
                        end else begin
                            w_acc_nxt = w_sum;
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (w_is_term) begin
                        if (r_cnt == '0) begin
                            w_fail      = 1'b1;
                            w_fail_code = c_code_empty;
                        end else begin
                            w_commit     = 1'b1;
                            w_commit_src = r_acc;
                        end
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = c_code_char;
                    end
                end
                S_ERR: begin
                    if (w_is_term) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        if (w_commit) begin
            w_out_nxt       = OUT_W'(r_neg ? (~w_commit_src + c_one) : w_commit_src);
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_neg_nxt       = 1'b0;
            w_state_nxt     = S_IDLE;
        end

        // A lone '-' is already framed by its terminator, so it returns straight to IDLE.
        if (w_fail) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = w_fail_code;
            w_acc_nxt      = '0;
            w_cnt_nxt      = '0;
            w_neg_nxt      = 1'b0;
            w_state_nxt    = (w_fail_code == c_code_empty) ? S_IDLE : S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_neg       <= w_neg_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ascii_decimal_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_decimal_parser
// Brief    : Scoreboard bench for ascii_decimal_parser over four parameter sets.
// Revision : 1.0
// ============================================================================
module tb_ascii_decimal_parser;

    typedef struct {
        int         inst;
        int         cyc;
        bit         is_err;
        logic [9:0] val;
        logic [1:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_b;
    logic       dv [4];
    logic [9:0] o  [4];
    logic       ov [4];
    logic       er [4];
    logic [1:0] ec [4];
    logic       bz [4];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: defaults, 1: four digits, 2: signed, 3: fixed length
    ascii_decimal_parser u0 (
        .clk(clk), .rst(rst_n), .in(in_b), .w_RX_dv(dv[0]), .out(o[0]),
        .out_valid(ov[0]), .err(er[0]), .err_code(ec[0]), .busy(bz[0]));
    ascii_decimal_parser #(.MAX_DIGITS(4)) u1 (
        .clk(clk), .rst(rst_n), .in(in_b), .w_RX_dv(dv[1]), .out(o[1]),
        .out_valid(ov[1]), .err(er[1]), .err_code(ec[1]), .busy(bz[1]));
    ascii_decimal_parser #(.ALLOW_SIGN(1)) u2 (
        .clk(clk), .rst(rst_n), .in(in_b), .w_RX_dv(dv[2]), .out(o[2]),
        .out_valid(ov[2]), .err(er[2]), .err_code(ec[2]), .busy(bz[2]));
    ascii_decimal_parser #(.FIXED_LEN(1)) u3 (
        .clk(clk), .rst(rst_n), .in(in_b), .w_RX_dv(dv[3]), .out(o[3]),
        .out_valid(ov[3]), .err(er[3]), .err_code(ec[3]), .busy(bz[3]));

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // kind 0: no response; 1: out_valid with value v; 2: err with code v, at byte index 'at'
    task automatic send_str(input int inst, input string s, input int kind,
                            input int v, input int at);
        exp_t e;
        for (int k = 0; k < s.len(); k++) begin
            @(posedge clk);
            #1;
            if (kind != 0 && k == at) begin
                e.inst   = inst;
                e.cyc    = cyc + 1;
                e.is_err = (kind == 2);
                e.val    = 10'(v);
                e.code   = 2'(v);
                sb.push_back(e);
            end
            in_b      = s[k];
            dv[inst]  = 1'b1;
            @(posedge clk);
            #1;
            dv[inst]  = 1'b0;
            in_b      = 8'h00;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sb.size() > 0 && sb[0].inst == i && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                chk($sformatf("u%0d_out_valid", i), ov[i], !mon_e.is_err);
                chk($sformatf("u%0d_err", i), er[i], mon_e.is_err);
                if (mon_e.is_err) chk($sformatf("u%0d_err_code", i), ec[i], mon_e.code);
                else              chk($sformatf("u%0d_out", i), o[i], mon_e.val);
            end else if (ov[i] || er[i]) begin
                n_vec++;
                n_err++;
                $display("FAIL u%0d_spurious: out_valid=%0b err=%0b out=%0d at cycle %0d, required no pulse",
                         i, ov[i], er[i], o[i], cyc);
            end
        end
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL u%0d_missing: no pulse by cycle %0d, required one at cycle %0d",
                     mon_e.inst, cyc, mon_e.cyc);
        end
    end

    initial begin
        rst_n = 1'b0;
        in_b  = 8'h00;
        for (int i = 0; i < 4; i++) dv[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_rst_out", i), o[i], 0);
            chk($sformatf("u%0d_rst_out_valid", i), ov[i], 0);
            chk($sformatf("u%0d_rst_err", i), er[i], 0);
            chk($sformatf("u%0d_rst_err_code", i), ec[i], 0);
            chk($sformatf("u%0d_rst_busy", i), bz[i], 0);
        end
        rst_n = 1'b1;

        // defaults
        send_str(0, "123\015", 1, 123, 3);
        send_str(0, "\015\012 5\012", 1, 5, 4);
        send_str(0, "1A7\015", 2, 1, 1);
        send_str(0, "42\015", 1, 42, 2);
        chk("u0_err_code_held", ec[0], 1);
        chk("u0_out_held", o[0], 42);
        send_str(0, "1234", 2, 2, 3);
        chk("u0_busy_in_err", bz[0], 1);
        send_str(0, "\015", 0, 0, 0);
        chk("u0_busy_after_term", bz[0], 0);
        send_str(0, "x,", 2, 1, 0);
        send_str(0, "0,", 1, 0, 1);
        send_str(0, "999 ", 1, 999, 3);

        // four digits
        send_str(1, "1024\015", 2, 2, 3);
        send_str(1, "1023\015", 1, 1023, 4);

        // signed
        send_str(2, "-45 ", 1, 10'h3D3, 3);
        send_str(2, "- ", 2, 3, 1);
        chk("u2_busy_after_empty", bz[2], 0);
        send_str(2, "-512\015", 1, 10'h200, 4);
        send_str(2, "-513\015", 2, 2, 3);
        send_str(2, "511\015", 1, 511, 3);
        send_str(2, "512\015", 2, 2, 2);
        send_str(2, "5-\015", 2, 1, 1);

        // fixed length
        send_str(3, "007", 1, 7, 2);
        send_str(3, "\015", 0, 0, 0);
        chk("u3_busy_idle", bz[3], 0);
        send_str(3, "12", 0, 0, 0);
        chk("u3_busy_partial", bz[3], 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("u3_busy_after_rst", bz[3], 0);
        chk("u3_out_after_rst", o[3], 0);
        send_str(3, "3\015", 1, 3, 1);
        send_str(3, "456", 1, 456, 2);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
